// File: rtl/funct_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : funct_generator_pkg
// Purpose  : Shared defaults and types for the function-generator sample FIFO.
//            Provides the default geometry, pointer/count/sample typedefs and
//            the encoding of the per-cycle FIFO operation.
// Revision : 1.0 - initial release
// ============================================================================
package funct_generator_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 32;
  localparam int unsigned FIFO_DEPTH_LOG2 = 4;
  localparam int unsigned FIFO_AFULL_TH   = 12;

  typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
  typedef logic [FIFO_DEPTH_LOG2:0]   cnt_t;
  typedef logic [FIFO_DATA_WIDTH-1:0] sample_t;

  // Bit 1 = write accepted, bit 0 = read accepted.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

endpackage : funct_generator_pkg
`default_nettype wire

// File: rtl/funct_generator_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : funct_generator_fifo_mem
// Purpose  : Simple dual-port sample RAM: one write port, one registered read
//            port. The array itself has no reset so it maps onto block or
//            distributed RAM; only the read output register is reset.
// Ports    : clk, rst      - clock / async active-high reset (read reg only)
//            i_we, i_waddr, i_wdata - write port
//            i_re, i_raddr - read request; o_rdata updates on the next edge
//            o_rdata       - registered read data, holds when i_re is low
// Revision : 1.0 - initial release
// ============================================================================
module funct_generator_fifo_mem
  import funct_generator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned c_ENTRIES = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:c_ENTRIES-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Same-address read and write in one cycle (full FIFO, simultaneous
  // read/write) returns the old entry: the read samples before the write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : funct_generator_fifo_mem
`default_nettype wire

// File: rtl/funct_generator_fifo.sv
`default_nettype none
// ============================================================================
// Module   : funct_generator_fifo
// Purpose  : Single-clock sample FIFO behind the function generator. Holds
//            samples for a slower consumer, with a 1-cycle registered read
//            port, occupancy count, almost-full threshold and sticky
//            overflow / underflow flags.
// Ports    : clk, rst       - clock / async active-high reset
//            wr_en_i, wr_data_i - write request and sample
//            rd_en_i        - read request
//            clr_flags_i    - clears sticky flags (set events win)
//            rd_data_o, rd_valid_o - read data and its one-cycle valid pulse
//            full_o, empty_o, almost_full_o, count_o - occupancy status
//            overflow_o, underflow_o - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module funct_generator_fifo
  import funct_generator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2,
  parameter int unsigned AFULL_TH   = FIFO_AFULL_TH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic                  clr_flags_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE  = (DEPTH_LOG2)'(1);
  localparam logic [DEPTH_LOG2:0]   c_CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   c_CNT_FULL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   c_CNT_AF   = (DEPTH_LOG2+1)'(AFULL_TH);

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_accept;
  logic                  w_wr_accept;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  fifo_op_e              w_op;

  assign w_full  = (r_count == c_CNT_FULL);
  assign w_empty = (r_count == '0);

  // A read frees the slot the write needs, so a full FIFO still accepts a
  // write in a read cycle. An empty FIFO never forwards write data to a read.
  assign w_rd_accept = rd_en_i && !w_empty;
  assign w_wr_accept = wr_en_i && (!w_full || w_rd_accept);
  assign w_ovf_set   = wr_en_i && !w_wr_accept;
  assign w_unf_set   = rd_en_i && w_empty;

  always_comb begin
    w_op = fifo_op_e'({w_wr_accept, w_rd_accept});
  end

  funct_generator_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data_i),
    .i_re    (w_rd_accept),
    .i_raddr (r_rd_ptr),
    .o_rdata (rd_data_o)
  );

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_accept;
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_accept) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case (w_op)
        OP_WR:   r_count <= r_count + c_CNT_ONE;
        OP_RD:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as a clear keeps the flag up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clr_flags_i) begin
        r_overflow <= 1'b0;
      end
      if (w_unf_set) begin
        r_underflow <= 1'b1;
      end else if (clr_flags_i) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign rd_valid_o    = r_rd_valid;
  assign full_o        = w_full;
  assign empty_o       = w_empty;
  assign almost_full_o = (r_count >= c_CNT_AF);
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;
  assign underflow_o   = r_underflow;

endmodule : funct_generator_fifo
`default_nettype wire

// File: tb/tb_funct_generator_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_funct_generator_fifo
// Purpose  : Self-checking bench for funct_generator_fifo. A queue-based
//            reference model predicts occupancy, flags and read data; read
//            expectations go to a scoreboard drained by a separate monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_funct_generator_fifo;
  import funct_generator_pkg::*;

  localparam int DEPTH = 16;
  localparam int AF_TH = 12;

  logic        clk;
  logic        rst;
  logic        wr_en_i;
  logic [31:0] wr_data_i;
  logic        rd_en_i;
  logic        clr_flags_i;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        full_o;
  logic        empty_o;
  logic        almost_full_o;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic        underflow_o;

  funct_generator_fifo #(
    .DATA_WIDTH (32),
    .DEPTH_LOG2 (4),
    .AFULL_TH   (12)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en_i       (wr_en_i),
    .wr_data_i     (wr_data_i),
    .rd_en_i       (rd_en_i),
    .clr_flags_i   (clr_flags_i),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .almost_full_o (almost_full_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_q[$];     // FIFO contents, oldest first
  logic [31:0] exp_q[$];   // scoreboard of expected read data
  logic        m_valid = 1'b0;
  logic [31:0] m_last  = '0;
  logic        m_ovf   = 1'b0;
  logic        m_unf   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = m_q.size();
    chk("count_o",       32'(count_o),       32'(n));
    chk("empty_o",       32'(empty_o),       32'(n == 0));
    chk("full_o",        32'(full_o),        32'(n == DEPTH));
    chk("almost_full_o", 32'(almost_full_o), 32'(n >= AF_TH));
    chk("overflow_o",    32'(overflow_o),    32'(m_ovf));
    chk("underflow_o",   32'(underflow_o),   32'(m_unf));
    chk("rd_valid_o",    32'(rd_valid_o),    32'(m_valid));
    chk("rd_data_hold",  rd_data_o,          m_last);
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_last  = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // One clock of stimulus; the model advances at the edge, state checked 1ns later.
  task automatic step(input logic wr, input logic [31:0] d, input logic rd, input logic clr);
    bit ra, wa, was_empty;
    logic [31:0] v;
    wr_en_i     = wr;
    wr_data_i   = d;
    rd_en_i     = rd;
    clr_flags_i = clr;
    was_empty = (m_q.size() == 0);
    ra = rd && !was_empty;
    wa = wr && (m_q.size() < DEPTH || ra);
    @(posedge clk);
    if (ra) begin
      v = m_q.pop_front();
      exp_q.push_back(v);
      m_last = v;
    end
    if (wa) m_q.push_back(d);
    m_valid = ra;
    if (wr && !wa)      m_ovf = 1'b1;
    else if (clr)       m_ovf = 1'b0;
    if (rd && was_empty) m_unf = 1'b1;
    else if (clr)        m_unf = 1'b0;
    #1;
    check_state();
  endtask

  // Monitor: every valid read pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (rd_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %0h expected no read at %0t", rd_data_o, $time);
      end else begin
        chk("rd_data", rd_data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; wr_en_i = 1'b0; wr_data_i = '0; rd_en_i = 1'b0; clr_flags_i = 1'b0;
    #12;
    check_state();
    chk("rd_data_reset", rd_data_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fill to full with 1..16, then an overflowing write, then clear flags.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Read while empty, then empty + rd + wr (no fall-through).
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h77, 1'b1, 1'b0);
    // Set and clear in the same cycle: set wins.
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Full with simultaneous read and write of 0x55; 0x55 must come out last.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h55, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Randomised interleaving, long enough to wrap the pointers many times.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50,
           $urandom_range(0, 15) == 0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Mid-stream reset with five entries and a read pulse in flight.
    while (m_q.size() > 0) step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    check_state();
    chk("rd_data_midreset", rd_data_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'hBEEF, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_funct_generator_fifo
`default_nettype wire
